// File: rtl/mbc_pkg.sv
// Shared definitions for the mbc_target memory-bus register target:
// FSM state encoding, control-word bit positions and the error read value.
package mbc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mbc_state_e;

    localparam int BUSY = 0;
    localparam int ACK  = 1;
    localparam int ERR  = 2;

    localparam logic [31:0] ERR_READ_VAL = 32'h0000_0000;

    // Status word seen on the bus; every bit above ERR stays zero.
    function automatic logic [31:0] ctrl_word(input logic busy, input logic ack, input logic err);
        logic [31:0] w;
        w      = 32'h0000_0000;
        w[BUSY] = busy;
        w[ACK]  = ack;
        w[ERR]  = err;
        return w;
    endfunction

endpackage

// File: rtl/mbc_wait_ctr.sv
// Loadable down-counter used to time the wait states of a bus transaction.
// expired flags the last wait cycle (count of 1).
module mbc_wait_ctr #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    // Count register: load wins over decrement, saturates at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end else begin
            count <= count;
        end
    end

    assign expired = (count == CNT_W'(1));

endmodule

// File: rtl/mbc_target.sv
// Memory-bus register target: NUM_REGS word registers behind an
// IDLE/WAIT/RESP handshake. Define MBC_TARGET_ERR_EN to flag out-of-range addresses.
module mbc_target
    import mbc_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 8,
    parameter int WAIT_CYC = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDR_W-1:0]          mbc_in_ifc_address,
    input  logic [DATA_W-1:0]          mbc_in_ifc_write_data,
    input  logic                       mbc_in_ifc_write,
    input  logic                       mbc_in_ifc_read,
    output logic [DATA_W-1:0]          mbc_in_ifc_read_data,
    output logic [31:0]                mbc_in_ifc_control,
    output logic [NUM_REGS*DATA_W-1:0] reg_out
);

    localparam int                IDX_W    = $clog2(NUM_REGS);
    localparam logic [3:0]        WAIT_LD  = 4'(WAIT_CYC);
    localparam logic [ADDR_W-1:0] IDX_MASK = ADDR_W'(NUM_REGS * 4 - 1);

    mbc_state_e        state;
    logic [IDX_W-1:0]  cap_idx;
    logic [DATA_W-1:0] cap_data;
    logic              cap_write;
    logic              cap_oor;

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic              req;
    logic              live_oor;
    logic [IDX_W-1:0]  live_idx;
    logic              accept;
    logic              start_resp;
    logic [IDX_W-1:0]  txn_idx;
    logic [DATA_W-1:0] txn_data;
    logic              txn_write;
    logic              txn_oor;
    logic [3:0]        wait_count;
    logic              wait_expired;
    logic              unused_bits;

    assign req      = mbc_in_ifc_write | mbc_in_ifc_read;
    assign live_idx = mbc_in_ifc_address[IDX_W+1:2];

`ifdef MBC_TARGET_ERR_EN
    assign live_oor = ((mbc_in_ifc_address & ~IDX_MASK) != '0);
`else
    // Upper address bits alias onto the register window.
    assign live_oor = 1'b0;
`endif

    assign unused_bits = ^{mbc_in_ifc_address, wait_count, IDX_MASK};

    // With zero wait states the commit uses the live request, otherwise the captured one.
    always_comb begin
        accept     = 1'b0;
        start_resp = 1'b0;
        txn_idx    = cap_idx;
        txn_data   = cap_data;
        txn_write  = cap_write;
        txn_oor    = cap_oor;
        if (state == IDLE) begin
            accept     = req;
            start_resp = req && (WAIT_CYC == 0);
            txn_idx    = live_idx;
            txn_data   = mbc_in_ifc_write_data;
            txn_write  = mbc_in_ifc_write;
            txn_oor    = live_oor;
        end else if (state == WAIT) begin
            start_resp = wait_expired;
        end else begin
            start_resp = 1'b0;
        end
    end

    mbc_wait_ctr #(
        .CNT_W (4)
    ) u_wait_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (WAIT_LD),
        .dec      (state == WAIT),
        .count    (wait_count),
        .expired  (wait_expired)
    );

    // Handshake FSM with registered status word and request capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            mbc_in_ifc_control <= 32'h0000_0000;
            cap_idx            <= '0;
            cap_data           <= '0;
            cap_write          <= 1'b0;
            cap_oor            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        cap_idx   <= live_idx;
                        cap_data  <= mbc_in_ifc_write_data;
                        cap_write <= mbc_in_ifc_write;
                        cap_oor   <= live_oor;
                        if (WAIT_CYC == 0) begin
                            state              <= RESP;
                            mbc_in_ifc_control <= ctrl_word(1'b1, 1'b1, live_oor);
                        end else begin
                            state              <= WAIT;
                            mbc_in_ifc_control <= ctrl_word(1'b1, 1'b0, 1'b0);
                        end
                    end else begin
                        state              <= IDLE;
                        mbc_in_ifc_control <= 32'h0000_0000;
                    end
                end
                WAIT: begin
                    if (wait_expired) begin
                        state              <= RESP;
                        mbc_in_ifc_control <= ctrl_word(1'b1, 1'b1, cap_oor);
                    end else begin
                        state              <= WAIT;
                        mbc_in_ifc_control <= ctrl_word(1'b1, 1'b0, 1'b0);
                    end
                end
                RESP: begin
                    state              <= IDLE;
                    mbc_in_ifc_control <= 32'h0000_0000;
                end
                default: begin
                    state              <= IDLE;
                    mbc_in_ifc_control <= 32'h0000_0000;
                end
            endcase
        end
    end

    // Register file and read response, both updated on the edge entering RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            mbc_in_ifc_read_data <= '0;
        end else if (start_resp) begin
            if (txn_write) begin
                if (!txn_oor) begin
                    regs[txn_idx] <= txn_data;
                end
            end else if (txn_oor) begin
                mbc_in_ifc_read_data <= ERR_READ_VAL[DATA_W-1:0];
            end else begin
                mbc_in_ifc_read_data <= regs[txn_idx];
            end
        end
    end

    // Flatten the register file, register 0 in the LSBs.
    always_comb begin
        reg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_out[i*DATA_W +: DATA_W] = regs[i];
        end
    end

endmodule

// File: tb/tb_mbc_target.sv
// Bench for mbc_target: one instance with WAIT_CYC=1 and one with WAIT_CYC=0,
// directed table, multi-cycle corner sequences and randomized traffic vs a model.
module tb_mbc_target;

`ifdef MBC_TARGET_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  addr0, wd0, rd0, ctl0;
    logic         w0, r0;
    logic [255:0] ro0;
    logic [31:0]  addr1, wd1, rd1, ctl1;
    logic         w1, r1;
    logic [255:0] ro1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acks [2];
    int ack_cyc [2];
    logic [31:0] mregs [2][8];
    logic [31:0] mrd [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (ctl0[1]) begin acks[0]++; ack_cyc[0] = cyc; end
        if (ctl1[1]) begin acks[1]++; ack_cyc[1] = cyc; end
    end

    mbc_target #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(8), .WAIT_CYC(0)) dut0 (
        .clk(clk), .reset(reset), .mbc_in_ifc_address(addr0), .mbc_in_ifc_write_data(wd0),
        .mbc_in_ifc_write(w0), .mbc_in_ifc_read(r0), .mbc_in_ifc_read_data(rd0),
        .mbc_in_ifc_control(ctl0), .reg_out(ro0));

    mbc_target #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(8), .WAIT_CYC(1)) dut1 (
        .clk(clk), .reset(reset), .mbc_in_ifc_address(addr1), .mbc_in_ifc_write_data(wd1),
        .mbc_in_ifc_write(w1), .mbc_in_ifc_read(r1), .mbc_in_ifc_read_data(rd1),
        .mbc_in_ifc_control(ctl1), .reg_out(ro1));

    typedef struct {
        bit          wr;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int w, input logic [31:0] a, input logic [31:0] d, input bit wr, input bit rd);
        if (w == 0) begin addr0 = a; wd0 = d; w0 = wr; r0 = rd; end
        else        begin addr1 = a; wd1 = d; w1 = wr; r1 = rd; end
    endtask

    function automatic logic [31:0] get_ctl(input int w);
        return (w == 0) ? ctl0 : ctl1;
    endfunction

    function automatic logic [31:0] get_rd(input int w);
        return (w == 0) ? rd0 : rd1;
    endfunction

    function automatic logic [255:0] get_ro(input int w);
        return (w == 0) ? ro0 : ro1;
    endfunction

    function automatic logic [255:0] model_pack(input int w);
        logic [255:0] p;
        for (int i = 0; i < 8; i++) p[i*32 +: 32] = mregs[w][i];
        return p;
    endfunction

    // Behavioural model: word index is (addr/4) mod 8, out of range means addr >= 32.
    function automatic void model_apply(input int w, input bit wr, input bit rd, input logic [31:0] a,
                                        input logic [31:0] d, output logic [31:0] erd, output bit eerr);
        int idx;
        bit oor;
        idx  = int'((a / 32'd4) % 32'd8);
        oor  = ERR_EN && (a >= 32'd32);
        eerr = oor;
        if (wr) begin
            if (!oor) mregs[w][idx] = d;
        end else if (rd) begin
            mrd[w] = oor ? 32'h0 : mregs[w][idx];
        end
        erd = mrd[w];
    endfunction

    function automatic void model_reset();
        for (int w = 0; w < 2; w++) begin
            mrd[w] = 32'h0;
            for (int i = 0; i < 8; i++) mregs[w][i] = 32'h0;
        end
    endfunction

    // One request pulse; checks latency, status, read data, single ack and register image.
    task automatic txn(input int w, input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input bit exp_err, input bit junk);
        int n;
        int a0;
        logic [31:0] c;
        a0 = acks[w];
        drive(w, a, d, wr, rd);
        @(posedge clk); #1;
        if (junk) drive(w, 32'h0000_000C, 32'hDEAD_BEEF, 1'b1, 1'b0);
        else      drive(w, 32'h0, 32'h0, 1'b0, 1'b0);
        n = 1;
        c = get_ctl(w);
        while (!c[1] && n < 40) begin
            @(posedge clk); #1;
            n++;
            c = get_ctl(w);
        end
        drive(w, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("latency", 256'(n), 256'((w == 0) ? 1 : 2));
        chk("resp_ctrl", 256'(c), 256'({29'h0, exp_err, 1'b1, 1'b1}));
        chk("read_data", 256'(get_rd(w)), 256'(exp_rd));
        @(posedge clk); #1;
        chk("idle_ctrl", 256'(get_ctl(w)), 256'h0);
        chk("one_ack", 256'(acks[w] - a0), 256'd1);
        chk("reg_out", get_ro(w), model_pack(w));
    endtask

    initial begin
        vec_t tbl [7];
        logic [31:0] erd;
        bit eerr;
        int a_before;
        int first_ack;

        tbl[0] = '{1'b1, 1'b0, 32'h0000_0008, 32'hA5A5_0001, 32'h0000_0000, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 32'h0000_0008, 32'h0000_0000, 32'hA5A5_0001, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 32'h0000_0004, 32'h0000_1234, 32'hA5A5_0001, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 32'h0000_0007, 32'h0000_0000, 32'h0000_1234, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 32'h0000_0040, 32'hFFFF_0000, 32'h0000_1234, ERR_EN};
        tbl[5] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, ERR_EN ? 32'h0 : 32'hFFFF_0000, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 32'h0000_0040, 32'h0000_0000, ERR_EN ? 32'h0 : 32'hFFFF_0000, ERR_EN};

        acks[0] = 0; acks[1] = 0;
        model_reset();
        drive(0, 32'h0, 32'h0, 1'b0, 1'b0);
        drive(1, 32'h0, 32'h0, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_ctrl1", 256'(ctl1), 256'h0);
        chk("rst_ctrl0", 256'(ctl0), 256'h0);
        chk("rst_regs1", ro1, 256'h0);
        chk("rst_rdata1", 256'(rd1), 256'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            model_apply(1, tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].data, erd, eerr);
            txn(1, tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].data, tbl[i].exp_rd, tbl[i].exp_err, 1'b0);
        end

        // Write issued while busy must be dropped: reg 3 untouched.
        model_apply(1, 1'b1, 1'b0, 32'h0000_0010, 32'h0BAD_0004, erd, eerr);
        txn(1, 1'b1, 1'b0, 32'h0000_0010, 32'h0BAD_0004, erd, 1'b0, 1'b1);
        chk("busy_drop_reg3", 256'(ro1[127:96]), 256'h0);

        // Reset in the middle of WAIT aborts the write with no ack.
        a_before = acks[1];
        drive(1, 32'h0000_0008, 32'h5555_AAAA, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(1, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("wait_busy", 256'(ctl1), 256'h1);
        reset = 1'b1;
        #1;
        chk("midrst_ctrl", 256'(ctl1), 256'h0);
        chk("midrst_regs", ro1, 256'h0);
        chk("midrst_rdata", 256'(rd1), 256'h0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        chk("midrst_noack", 256'(acks[1] - a_before), 256'h0);
        chk("midrst_idle", 256'(ctl1), 256'h0);
        chk("midrst_regs2", ro1, 256'h0);

        // Zero wait states: back-to-back reads separated by one idle cycle.
        model_apply(0, 1'b1, 1'b0, 32'h0, 32'h0000_0011, erd, eerr);
        txn(0, 1'b1, 1'b0, 32'h0, 32'h0000_0011, erd, 1'b0, 1'b0);
        model_apply(0, 1'b1, 1'b0, 32'h4, 32'h0000_0022, erd, eerr);
        txn(0, 1'b1, 1'b0, 32'h4, 32'h0000_0022, erd, 1'b0, 1'b0);
        txn(0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0000_0011, 1'b0, 1'b0);
        first_ack = ack_cyc[0];
        txn(0, 1'b0, 1'b1, 32'h4, 32'h0, 32'h0000_0022, 1'b0, 1'b0);
        chk("b2b_spacing", 256'(ack_cyc[0] - first_ack), 256'd2);
        mrd[0] = 32'h0000_0022;

        // Randomized traffic on both instances.
        for (int i = 0; i < 120; i++) begin
            int w;
            int kind;
            bit wr;
            bit rd;
            logic [31:0] a;
            logic [31:0] d;
            w    = i % 2;
            kind = $urandom_range(0, 2);
            wr   = (kind != 1);
            rd   = (kind != 0);
            a    = 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a = a | (32'($urandom_range(1, 255)) << 5);
            d    = 32'($urandom);
            model_apply(w, wr, rd, a, d, erd, eerr);
            txn(w, wr, rd, a, d, erd, eerr, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mbc_target.md
MBC_TARGET -- requirements
Module: mbc_target

Interface
REQ-001 Parameter ADDR_W, default 32, memory-bus address width; SHALL be 8 or more.
REQ-002 Parameter DATA_W, default 32, data width; SHALL be 8, 16 or 32.
REQ-003 Parameter NUM_REGS, default 8, register count; SHALL be a power of 2, from 2 to 64.
REQ-004 Parameter WAIT_CYC, default 1, wait states inserted before a response; range 0 to 15.
REQ-005 Clocking and reset SHALL be one clock `clk` and one reset `reset`, which is asynchronous and active-high.
REQ-006 `clk`  input  1  rising-edge clock.
REQ-007 `reset`  input  1  asynchronous active-high reset.
REQ-008 `mbc_in_ifc_address`  input  ADDR_W  byte address; word index is bits [log2(NUM_REGS)+1:2].
REQ-009 `mbc_in_ifc_write_data`  input  DATA_W  write data.
REQ-010 `mbc_in_ifc_write`  input  1  write request.
REQ-011 `mbc_in_ifc_read`  input  1  read request.
REQ-012 `mbc_in_ifc_read_data`  output  DATA_W  read response data.
REQ-013 `mbc_in_ifc_control`  output  32  status: bit0 busy, bit1 ack, bit2 err; bits 31:3 are 0.
REQ-014 `reg_out`  output  NUM_REGS*DATA_W  all register contents, with register 0 in the LSBs.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-016 In IDLE, a request (read or write high) SHALL be captured (address, data, type) and the FSM SHALL go to WAIT; if WAIT_CYC=0 it SHALL go directly to RESP.
REQ-017 If read and write are both high in IDLE, write SHALL win and the read SHALL be dropped.
REQ-018 WAIT SHALL count down from WAIT_CYC; when the count reaches 1, the FSM SHALL move to RESP.
REQ-019 RESP SHALL last exactly one cycle, pulse ack=1 and return to IDLE.
REQ-020 Latency from request edge to ack SHALL be WAIT_CYC+1 cycles.
REQ-021 busy SHALL be 1 in WAIT and RESP and 0 in IDLE; requests while busy=1 SHALL be ignored, not queued.
REQ-022 Write commit: the selected register SHALL update on the RESP clock edge with the captured data.
REQ-023 Read: read_data SHALL be valid in the RESP cycle and SHALL hold its value until the next read response.
REQ-024 A new request in the cycle after RESP (IDLE) SHALL be accepted normally (back-to-back requests).
REQ-025 Address bits [1:0] SHALL be ignored; there are no partial-word writes.

Reset
REQ-026 On reset, the FSM SHALL go to IDLE, the wait counter to 0, all registers to 0, and read_data to 0.
REQ-027 On reset, control SHALL go to 0.
REQ-028 Reset asserted mid-transaction SHALL abort it with no register update and no ack.

Configuration
REQ-029 Macro MBC_TARGET_ERR_EN defined: a request is out of range when any address bit above log2(NUM_REGS)+1 is 1.
REQ-030 An out-of-range request SHALL get normal timing, with ack=1 and err=1 in RESP.
REQ-031 An out-of-range write SHALL be discarded, and an out-of-range read SHALL return all-zero read_data.
REQ-032 Macro MBC_TARGET_ERR_EN undefined: upper address bits SHALL be ignored (aliasing), and err SHALL be tied to 0.

Structure
REQ-033 Shared package mbc_pkg SHALL hold the FSM state enum, the control bit-index constants (BUSY=0, ACK=1, ERR=2) and the err-read value (0).
REQ-034 Sub-module mbc_wait_ctr SHALL be a loadable down-counter that flags expiry; the register file SHALL stay inline.

Verification
REQ-035 Reset: assert reset mid-WAIT -> control=0, FSM IDLE, all reg_out=0, no ack.
REQ-036 Write then read (WAIT_CYC=1): write 0xA5A5_0001 to addr 0x8 -> ack at cycle 2, reg 2 updated; read 0x8 -> read_data=0xA5A5_0001 with ack.
REQ-037 Collision: read=write=1, addr 0x4, data 0x1234 -> reg 1=0x1234, single ack, read_data unchanged.
REQ-038 Busy drop: second write to addr 0xC issued during WAIT -> reg 3 stays 0, only one ack.
REQ-039 WAIT_CYC=0: read addr 0x0 -> ack in the next cycle; back-to-back reads of addr 0x0 and 0x4 -> two acks separated by one IDLE cycle.
REQ-040 MBC_TARGET_ERR_EN, NUM_REGS=8: write addr 0x40 -> ack=1, err=1, all regs unchanged; without the macro -> reg 0 written (alias).
